// File: rtl/div_seq.sv
// Iterative 32-step restoring divider (DIV/DIVU). Result is ready 33 cycles after the start cycle, or 2 for a zero divisor.
// stallreq_o holds the pipeline while busy; the result is held in END for as long as start_i stays high.
module div_seq #(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic                  annul_i,
    input  logic                  signed_div_i,
    input  logic [DATA_W-1:0]     opdata1_i,
    input  logic [DATA_W-1:0]     opdata2_i,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  ready_o,
    output logic                  stallreq_o
);

    localparam int W = DATA_W;

    typedef enum logic [1:0] {
        S_FREE,
        S_BYZERO,
        S_DIVON,
        S_END
    } state_t;

    state_t           state_q, state_d;
    logic [5:0]       cnt_q, cnt_d;
    logic [2*W:0]     work_q, work_d;
    logic [W-1:0]     dvsr_q, dvsr_d;
    logic             q_neg_q, q_neg_d;
    logic             r_neg_q, r_neg_d;
    logic [2*W-1:0]   result_q, result_d;
    logic             ready_q, ready_d;

    logic [W-1:0]     mag1, mag2;
    logic [2*W:0]     shifted, step_res;
    logic [W:0]       trial;
    logic             no_borrow;
    logic [W-1:0]     quo, rem;

    // Operand magnitudes; signs are remembered separately for the final fix-up.
    always_comb begin
        mag1 = (signed_div_i && opdata1_i[W-1]) ? -opdata1_i : opdata1_i;
        mag2 = (signed_div_i && opdata2_i[W-1]) ? -opdata2_i : opdata2_i;
    end

    always_comb begin
        shifted   = work_q << 1;
        no_borrow = shifted[2*W:W] >= {1'b0, dvsr_q};
        trial     = shifted[2*W:W] - {1'b0, dvsr_q};
        step_res  = shifted;
        if (no_borrow) begin
            step_res[2*W:W] = trial;
            step_res[0]     = 1'b1;
        end
        quo = q_neg_q ? -step_res[W-1:0]   : step_res[W-1:0];
        rem = r_neg_q ? -step_res[2*W-1:W] : step_res[2*W-1:W];
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        work_d     = work_q;
        dvsr_d     = dvsr_q;
        q_neg_d    = q_neg_q;
        r_neg_d    = r_neg_q;
        result_d   = result_q;
        ready_d    = ready_q;
        stallreq_o = 1'b0;
        case (state_q)
            S_FREE: begin
                if (start_i && !annul_i) begin
                    stallreq_o = 1'b1;
                    q_neg_d    = signed_div_i && (opdata1_i[W-1] ^ opdata2_i[W-1]);
                    r_neg_d    = signed_div_i && opdata1_i[W-1];
                    dvsr_d     = mag2;
                    work_d     = {{(W+1){1'b0}}, mag1};
                    cnt_d      = '0;
                    state_d    = (opdata2_i == '0) ? S_BYZERO : S_DIVON;
                end
                result_d = '0;
                ready_d  = 1'b0;
            end
            S_BYZERO: begin
                stallreq_o = 1'b1;
                if (annul_i) begin
                    state_d = S_FREE;
                end else begin
                    result_d = '0;
                    ready_d  = 1'b1;
                    state_d  = S_END;
                end
            end
            S_DIVON: begin
                stallreq_o = 1'b1;
                if (annul_i) begin
                    state_d = S_FREE;
                    cnt_d   = '0;
                end else begin
                    work_d = step_res;
                    cnt_d  = cnt_q + 6'd1;
                    // Final step: apply sign fix-up to the freshly computed pair.
                    if (cnt_q == 6'(W-1)) begin
                        cnt_d    = '0;
                        result_d = {rem, quo};
                        ready_d  = 1'b1;
                        state_d  = S_END;
                    end
                end
            end
            S_END: begin
                if (!start_i) begin
                    result_d = '0;
                    ready_d  = 1'b0;
                    state_d  = S_FREE;
                end
            end
            default: state_d = S_FREE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_FREE;
            cnt_q    <= '0;
            work_q   <= '0;
            dvsr_q   <= '0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            result_q <= '0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            work_q   <= work_d;
            dvsr_q   <= dvsr_d;
            q_neg_q  <= q_neg_d;
            r_neg_q  <= r_neg_d;
            result_q <= result_d;
            ready_q  <= ready_d;
        end
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;

endmodule

// File: tb/tb_div_seq.sv
// Bench for div_seq: driver checks stall/ready timing per cycle, monitor scores results against a reference model.
module tb_div_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i = 1'b0;
    logic        annul_i = 1'b0;
    logic        signed_div_i = 1'b0;
    logic [31:0] opdata1_i = '0;
    logic [31:0] opdata2_i = '0;
    logic [63:0] result_o;
    logic        ready_o;
    logic        stallreq_o;

    int checks = 0;
    int errors = 0;

    logic [63:0] exp_q[$];
    logic [63:0] cur_exp = '0;
    bit          prev_rdy = 1'b0;

    always #5 clk = ~clk;

    div_seq #(.DATA_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .result_o     (result_o),
        .ready_o      (ready_o),
        .stallreq_o   (stallreq_o)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain arithmetic; the one signed overflow case wraps.
    function automatic logic [63:0] ref_div(input bit s, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q;
        logic [31:0] r;
        if (b == 32'd0) return 64'd0;
        if (!s) begin
            q = a / b;
            r = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end
        return {r, q};
    endfunction

    // Monitor: pop on each rising ready, check hold while high, zero while low.
    always @(negedge clk) begin
        if (ready_o && !prev_rdy) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_ready: got ready with empty scoreboard at %0t", $time);
            end else begin
                cur_exp = exp_q.pop_front();
                check("result", result_o, cur_exp);
            end
        end else if (ready_o) begin
            check("result_hold", result_o, cur_exp);
        end else begin
            check("result_idle", result_o, 64'd0);
        end
        prev_rdy = ready_o;
    end

    // One operation from start cycle 0; annul_cyc>0 pulses annul in that cycle, hold keeps start high into END.
    task automatic do_op(input bit s, input logic [31:0] a, input logic [31:0] b,
                         input int annul_cyc, input int hold);
        int lat;
        bit live;
        lat = (b == 32'd0) ? 2 : 33;
        @(posedge clk); #1;
        start_i      = 1'b1;
        annul_i      = 1'b0;
        signed_div_i = s;
        opdata1_i    = a;
        opdata2_i    = b;
        if (annul_cyc == 0) exp_q.push_back(ref_div(s, a, b));
        @(negedge clk);
        check("stall_cycle0", 64'(stallreq_o), 64'd1);
        @(posedge clk); #1;
        opdata1_i    = $urandom;
        opdata2_i    = $urandom;
        signed_div_i = 1'($urandom_range(0, 1));
        for (int k = 1; k <= lat + hold + 1; k++) begin
            start_i = (hold > 0) && (k < lat + hold);
            annul_i = (k == annul_cyc);
            live    = (annul_cyc == 0) || (k <= annul_cyc);
            @(negedge clk);
            check("stall", 64'(stallreq_o), 64'(live && (k < lat)));
            check("ready", 64'(ready_o), 64'((annul_cyc == 0) && (k >= lat) && (k <= lat + hold)));
            @(posedge clk); #1;
        end
        start_i = 1'b0;
        annul_i = 1'b0;
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        rst = 1'b1;
        #1 rst = 1'b0;
        #3;
        check("rst_ready", 64'(ready_o), 64'd0);
        check("rst_result", result_o, 64'd0);
        check("rst_stall", 64'(stallreq_o), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        do_op(1'b0, 32'd100, 32'd7, 0, 0);
        do_op(1'b1, 32'hFFFF_FFF9, 32'd2, 0, 0);
        do_op(1'b0, 32'd5, 32'd0, 0, 0);
        do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
        do_op(1'b0, 32'd1000, 32'd3, 10, 0);
        do_op(1'b0, 32'hDEAD_BEEF, 32'h0000_1234, 0, 0);
        do_op(1'b1, 32'hFFFF_FF9C, 32'd0, 1, 0);
        do_op(1'b1, 32'hFFFF_FF9C, 32'd7, 0, 3);
        do_op(1'b1, 32'd7, 32'hFFFF_FFFE, 0, 0);

        // start with annul in FREE is not accepted
        @(posedge clk); #1;
        start_i   = 1'b1;
        annul_i   = 1'b1;
        opdata1_i = 32'd50;
        opdata2_i = 32'd5;
        @(negedge clk);
        check("annul_free_stall", 64'(stallreq_o), 64'd0);
        @(posedge clk); #1;
        start_i = 1'b0;
        annul_i = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("annul_free_ready", 64'(ready_o), 64'd0);
            check("annul_free_idle_stall", 64'(stallreq_o), 64'd0);
        end

        // asynchronous reset in the middle of DIVON
        @(posedge clk); #1;
        start_i      = 1'b1;
        signed_div_i = 1'b0;
        opdata1_i    = 32'd12345;
        opdata2_i    = 32'd11;
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk); #2;
        rst = 1'b0;
        #1;
        check("midrst_ready", 64'(ready_o), 64'd0);
        check("midrst_result", result_o, 64'd0);
        check("midrst_stall", 64'(stallreq_o), 64'd0);
        start_i = 1'b1;
        #1;
        check("midrst_stall_start", 64'(stallreq_o), 64'd1);
        start_i = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("postrst_ready", 64'(ready_o), 64'd0);
            check("postrst_stall", 64'(stallreq_o), 64'd0);
        end
        do_op(1'b0, 32'd12345, 32'd11, 0, 0);

        for (int i = 0; i < 20; i++) begin
            ra = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 4))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 15));
                2:       rb = 32'hFFFF_FFFF;
                default: rb = $urandom;
            endcase
            do_op(1'($urandom_range(0, 1)), ra, rb, 0, $urandom_range(0, 2));
        end

        @(negedge clk);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
